ascii_string_update_ctrl: RTL and testbench
===========================================

# ascii_string_update_ctrl

Frame-synchronous update controller for the 48-character text line renderer. Two requesters (e.g. the equalizer parameter formatter and the menu logic) write characters into a shadow buffer through valid/ready handshakes under round-robin arbitration. On commit, the shadow buffer is copied to the 384-bit display string at the next start of vertical blank, so the renderer never shows a half-updated line.

## Interface
- `VBLANK_LINE`, default 480: DrawY value marking the first blanking line.
- `NUM_CHARS`, default 48: characters per line. Fixed; the output width is 8*NUM_CHARS.
- `Clk`  in  1: pixel clock domain clock.
- `Reset`  in  1: asynchronous, active-high reset.
- `DrawY`  in  10: current scan line from the VGA controller.
- `a_valid`  in  1: requester A write request.
- `a_index`  in  6: requester A character slot, 0..47.
- `a_char`  in  8: requester A ASCII code.
- `a_ready`  out  1: requester A write accepted this cycle.
- `b_valid`, `b_index`, `b_char`, `b_ready`: same as A, for requester B.
- `commit`  in  1: single-cycle pulse requesting a shadow-to-display copy.
- `pending`  out  1: a commit is waiting for vertical blank.
- `string_out`  out  384: display string. Slot 0 is at [383:376] (leftmost); slot k is at [383-8k:376-8k].
- `index_err`  out  1: sticky flag. Set when an accepted write has index ≥ 48.

## Operation
- States:
  - IDLE: writes accepted.
  - PENDING: commit latched; writes stalled.
  - SWAP: one-cycle copy.
- Transitions:
  - IDLE → PENDING on `commit`=1.
  - PENDING → SWAP on `vblank_start`.
  - SWAP → IDLE unconditionally.
- `vblank_start` = (DrawY == VBLANK_LINE) && (DrawY_q != VBLANK_LINE), where DrawY_q is a register of DrawY.
- Arbitration:
  - Applies only in IDLE; ready is 0 for both requesters in PENDING and SWAP.
  - Only one valid requester: that requester gets ready=1.
  - Both valid: the requester not granted most recently wins. The `last_grant` register starts at B after reset, so A wins the first tie.
  - `last_grant` updates on every grant, contested or not.
- Write: when valid && ready, shadow[index] ← char at the clock edge.
  - index ≥ 48: shadow is unchanged, `index_err` ← 1, and the handshake still completes.
- Simultaneous write and commit in IDLE: the write is accepted and is included in the copy.
- `commit` while in PENDING or SWAP: ignored. It is not queued.
- SWAP: `string_out` ← shadow (all 384 bits). The shadow buffer retains its contents.
- Reset values:
  - shadow and `string_out`: all slots 0x20 (ASCII space).
  - state: IDLE.
  - `pending`: 0.
  - `index_err`: 0.
  - DrawY_q: 0.
  - `last_grant`: B.
- Reset asserted mid-operation (any state) returns to the reset values immediately. A pending commit is discarded.

## Timing
- `a_ready`/`b_ready` are combinational from state, valid inputs and `last_grant`. Ready never asserts without the corresponding valid.
- Write latency: shadow updates at the same edge that completes the handshake.
- `pending` is registered: high from the cycle after `commit` through the SWAP cycle; low in IDLE.
- Commit-to-display latency:
  - `vblank_start` is evaluated combinationally in PENDING.
  - SWAP is entered on the edge where PENDING and `vblank_start` are both true.
  - `string_out` changes on the following edge (end of SWAP).
  - Minimum latency is 3 cycles when the commit lands one cycle before `vblank_start`.
  - Maximum latency is about one frame.
- A commit issued in the same cycle as `vblank_start` (state IDLE) does not swap in that blanking interval; it waits for the next frame.
- `string_out` is stable outside the single SWAP update edge, so it changes only during blanking.

## Test plan
- Reset, then hold DrawY=100 for 10 cycles → `string_out` = 384'h2020…20, `pending`=0, `index_err`=0, both ready=0 with valids low.
- A writes 0x41 at index 0 and B writes 0x42 at index 47, in separate cycles; commit; step DrawY 479→480 → `string_out`[383:376]=0x41, `string_out`[7:0]=0x42, all other slots 0x20, one cycle after SWAP.
- A and B both valid for 4 cycles after reset → grants alternate A, B, A, B; each requester sees ready on alternating cycles.
- Commit, then A valid while PENDING → `a_ready`=0 until SWAP completes; the A write is accepted on the first IDLE cycle and is absent from `string_out` until the next commit and blank.
- Commit in the same cycle as the DrawY 479→480 step → no swap in that frame; `pending`=1 until the next 479→480 transition; second commit pulses while pending have no effect.
- Write with index 50 → `index_err`=1 and stays 1; shadow unchanged. Then assert Reset while PENDING → `pending`=0, `index_err`=0, `string_out` all spaces.

Source files
------------

// File: rtl/ascii_string_update_ctrl.sv
// Shadow-buffered 48-character text line: two round-robin writers fill a shadow
// copy, and a commit publishes it to the display string at the next vblank start.
module ascii_string_update_ctrl #(
  parameter int VBLANK_LINE = 480,
  parameter int NUM_CHARS   = 48
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [9:0]             DrawY,
  input  logic                   a_valid,
  input  logic [5:0]             a_index,
  input  logic [7:0]             a_char,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [5:0]             b_index,
  input  logic [7:0]             b_char,
  output logic                   b_ready,
  input  logic                   commit,
  output logic                   pending,
  output logic [8*NUM_CHARS-1:0] string_out,
  output logic                   index_err
);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_SWAP} state_e;
  // Ascending slot range puts slot 0 in the most significant byte.
  typedef logic [0:NUM_CHARS-1][7:0] line_t;

  state_e     state_q, state_d;
  logic [9:0] drawy_q;
  logic       last_b_q, last_b_d;
  line_t      shadow_q, disp_q;
  logic       pending_q;
  logic       err_q, err_d;
  logic       gnt_a, gnt_b, wr_en, vblank_start;
  logic [5:0] wr_idx;
  logic [7:0] wr_chr;

  assign vblank_start = (DrawY == 10'(VBLANK_LINE)) && (drawy_q != 10'(VBLANK_LINE));

  always_comb begin
    state_d = state_q;
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // On a tie the requester not granted most recently wins.
        gnt_a = a_valid && (!b_valid || last_b_q);
        gnt_b = b_valid && (!a_valid || !last_b_q);
        if (commit) state_d = S_PENDING;
      end
      S_PENDING: if (vblank_start) state_d = S_SWAP;
      S_SWAP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign wr_en    = gnt_a | gnt_b;
  assign wr_idx   = gnt_a ? a_index : b_index;
  assign wr_chr   = gnt_a ? a_char  : b_char;
  assign last_b_d = gnt_b ? 1'b1 : (gnt_a ? 1'b0 : last_b_q);
  assign err_d    = err_q | (wr_en && (wr_idx >= 6'(NUM_CHARS)));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      drawy_q   <= '0;
      last_b_q  <= 1'b1;
      shadow_q  <= line_t'({NUM_CHARS{8'h20}});
      disp_q    <= line_t'({NUM_CHARS{8'h20}});
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      drawy_q   <= DrawY;
      last_b_q  <= last_b_d;
      pending_q <= (state_d != S_IDLE);
      err_q     <= err_d;
      // Out-of-range writes still handshake but leave the shadow untouched.
      if (wr_en && (wr_idx < 6'(NUM_CHARS))) shadow_q[wr_idx] <= wr_chr;
      if (state_q == S_SWAP) disp_q <= shadow_q;
    end
  end

  assign a_ready    = gnt_a;
  assign b_ready    = gnt_b;
  assign pending    = pending_q;
  assign index_err  = err_q;
  assign string_out = disp_q;

endmodule

// File: tb/tb_ascii_string_update_ctrl.sv
// Directed bench for ascii_string_update_ctrl: writes, arbitration, commit/vblank timing, reset.
module tb_ascii_string_update_ctrl;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [9:0]   DrawY;
  logic         a_valid, b_valid, commit;
  logic [5:0]   a_index, b_index;
  logic [7:0]   a_char, b_char;
  logic         a_ready, b_ready, pending, index_err;
  logic [383:0] string_out;

  logic [0:47][7:0] sh_m, disp_m;
  logic [383:0] spaces;
  int checks = 0;
  int failures = 0;

  ascii_string_update_ctrl dut (
    .Clk(Clk), .Reset(Reset), .DrawY(DrawY),
    .a_valid(a_valid), .a_index(a_index), .a_char(a_char), .a_ready(a_ready),
    .b_valid(b_valid), .b_index(b_index), .b_char(b_char), .b_ready(b_ready),
    .commit(commit), .pending(pending), .string_out(string_out), .index_err(index_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    sh_m   = spaces;
    disp_m = spaces;
  endtask

  initial begin
    spaces  = {48{8'h20}};
    DrawY   = 10'd100;
    a_valid = 1'b0; a_index = '0; a_char = '0;
    b_valid = 1'b0; b_index = '0; b_char = '0;
    commit  = 1'b0;
    do_reset();

    // Reset state
    repeat (10) tick();
    #1;
    chk("rst_string", string_out, spaces);
    chk("rst_pending", 384'(pending), 384'(1'b0));
    chk("rst_err", 384'(index_err), 384'(1'b0));
    chk("rst_a_ready", 384'(a_ready), 384'(1'b0));
    chk("rst_b_ready", 384'(b_ready), 384'(1'b0));

    // Single writes from A and B, then commit and swap at vblank
    a_valid = 1'b1; a_index = 6'd0; a_char = 8'h41;
    #1;
    chk("wrA_a_ready", 384'(a_ready), 384'(1'b1));
    chk("wrA_b_ready", 384'(b_ready), 384'(1'b0));
    tick();
    sh_m[0] = 8'h41;
    a_valid = 1'b0;
    b_valid = 1'b1; b_index = 6'd47; b_char = 8'h42;
    #1;
    chk("wrB_b_ready", 384'(b_ready), 384'(1'b1));
    chk("wrB_a_ready", 384'(a_ready), 384'(1'b0));
    tick();
    sh_m[47] = 8'h42;
    b_valid = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    #1;
    chk("c1_pending", 384'(pending), 384'(1'b1));
    DrawY = 10'd479;
    tick();
    DrawY = 10'd480;
    tick();
    chk("c1_swap_pending", 384'(pending), 384'(1'b1));
    chk("c1_swap_old", string_out, disp_m);
    tick();
    disp_m = sh_m;
    chk("c1_string", string_out, disp_m);
    chk("c1_slot0", 384'(string_out[383:376]), 384'(8'h41));
    chk("c1_slot47", 384'(string_out[7:0]), 384'(8'h42));
    chk("c1_idle_pending", 384'(pending), 384'(1'b0));

    // Contested arbitration after reset: A, B, A, B
    DrawY = 10'd100;
    do_reset();
    a_valid = 1'b1; a_index = 6'd1; a_char = 8'h61;
    b_valid = 1'b1; b_index = 6'd2; b_char = 8'h62;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("arb%0d_a", i), 384'(a_ready), 384'((i % 2) == 0));
      chk($sformatf("arb%0d_b", i), 384'(b_ready), 384'((i % 2) == 1));
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    sh_m[1] = 8'h61;
    sh_m[2] = 8'h62;

    // A stalled while pending; its write lands after the swap
    commit = 1'b1;
    tick();
    commit = 1'b0;
    a_valid = 1'b1; a_index = 6'd3; a_char = 8'h43;
    #1;
    chk("st_a_ready_pend", 384'(a_ready), 384'(1'b0));
    chk("st_pending", 384'(pending), 384'(1'b1));
    DrawY = 10'd479;
    tick();
    DrawY = 10'd480;
    #1;
    chk("st_a_ready_vb", 384'(a_ready), 384'(1'b0));
    tick();
    chk("st_a_ready_swap", 384'(a_ready), 384'(1'b0));
    tick();
    disp_m = sh_m;
    chk("st_string", string_out, disp_m);
    chk("st_a_ready_idle", 384'(a_ready), 384'(1'b1));
    chk("st_idle_pending", 384'(pending), 384'(1'b0));
    tick();
    sh_m[3] = 8'h43;
    a_valid = 1'b0;
    #1;
    chk("st_not_shown", string_out, disp_m);

    // Commit coinciding with vblank start waits a full frame
    DrawY = 10'd479;
    tick();
    DrawY = 10'd480;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    #1;
    chk("late_pending", 384'(pending), 384'(1'b1));
    repeat (3) tick();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    #1;
    chk("late_pending2", 384'(pending), 384'(1'b1));
    chk("late_no_swap", string_out, disp_m);
    DrawY = 10'd479;
    tick();
    DrawY = 10'd480;
    tick();
    chk("late_swap_pending", 384'(pending), 384'(1'b1));
    commit = 1'b1;
    tick();
    commit = 1'b0;
    disp_m = sh_m;
    chk("late_string", string_out, disp_m);
    chk("late_idle_pending", 384'(pending), 384'(1'b0));
    tick();
    chk("late_not_queued", 384'(pending), 384'(1'b0));

    // Out-of-range index: sticky error, shadow untouched
    a_valid = 1'b1; a_index = 6'd50; a_char = 8'h5A;
    #1;
    chk("oor_a_ready", 384'(a_ready), 384'(1'b1));
    tick();
    a_valid = 1'b0;
    chk("oor_err", 384'(index_err), 384'(1'b1));
    repeat (3) tick();
    chk("oor_err_sticky", 384'(index_err), 384'(1'b1));
    commit = 1'b1;
    tick();
    commit = 1'b0;
    DrawY = 10'd479;
    tick();
    DrawY = 10'd480;
    tick();
    tick();
    disp_m = sh_m;
    chk("oor_string", string_out, disp_m);

    // Asynchronous reset while pending
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("rp_pending", 384'(pending), 384'(1'b1));
    Reset = 1'b1;
    #1;
    chk("rp_pending_clr", 384'(pending), 384'(1'b0));
    chk("rp_err_clr", 384'(index_err), 384'(1'b0));
    chk("rp_string", string_out, spaces);
    tick();
    Reset = 1'b0;
    DrawY = 10'd479;
    tick();
    DrawY = 10'd480;
    tick();
    tick();
    chk("rp_discarded", 384'(pending), 384'(1'b0));
    chk("rp_string2", string_out, spaces);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
